cc_arbiter: RTL and testbench
=============================

# cc_arbiter

Two-port arbiter and sequencer in front of the single convolution core (8-bit signed serial A/B in, 19-bit signed serial result out, MODE 0 = linear, 1 = circular). It grants the core to one of two requesters at a time using round-robin priority. It forwards the granted requester's input burst to the core, and routes the core's result burst back to that requester only. It also enforces the core's 9-sample length limit.

## Interface
- MAX_LEN, 9: maximum samples forwarded per job (core capacity)
- TIMEOUT, 16: cycles allowed between grant and first IN_VALIDn (used only with CCARB_TIMEOUT_EN)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset; clock CLK
- REQ0, REQ1  in  1  job request, held high until GNTn seen
- GNT0, GNT1  out  1  grant; high from grant until job end
- IN_VALID0/1, MODE0/1  in  1  requester input burst and mode
- IN_A0/1, IN_B0/1  in  8 signed  requester samples
- OUT_VALID0/1  out  1  result valid to requester
- OUT0/1  out  19 signed  result to requester
- BUSY  out  1  high whenever state != IDLE
- ERR  out  1  one-cycle pulse on overlength or timeout
- CC_IN_VALID, CC_MODE  out  1  to core
- CC_IN_A, CC_IN_B  out  8 signed  to core
- CC_OUT_VALID  in  1  from core
- CC_OUT  in  19 signed  from core

## Operation
- States: IDLE, GRANT, STREAM, WAIT_OUT, GAP.
- Priority pointer `last`: resets to 1, so requester 0 wins first.
- IDLE: if any REQ is high, grant the requester other than `last` when it requests, else the one requesting, then go to GRANT. GNTn is registered and rises on entry to GRANT.
- GRANT:
  - IN_VALIDn high: forward the sample, count = 1, go to STREAM.
  - REQn low before any IN_VALIDn: cancel, go to GAP.
- STREAM:
  - Forward each IN_VALIDn sample and increment count.
  - IN_VALIDn low: go to WAIT_OUT.
  - IN_VALIDn high with count == MAX_LEN: drop the sample, pulse ERR, go to WAIT_OUT. All remaining samples of that burst are ignored.
- WAIT_OUT: route CC_OUT_VALID/CC_OUT to the owner. Once CC_OUT_VALID has been seen high and then falls, go to GAP.
- GAP: one cycle. GNTn falls, `last` = owner, next state IDLE. This guarantees the core an idle cycle before the next burst.
- MODEn is forwarded only on the first sample of a burst. CC_MODE holds 0 otherwise.
- Non-granted requester: its IN_VALID/IN_A/IN_B are ignored; its OUT_VALID and OUT are held at 0.
- No arithmetic is performed. Data passes bit-exact at 8 bits in and 19 bits out.

## Timing
- Reset values: GNT0/1 = 0, OUT_VALID0/1 = 0, OUT0/1 = 0, BUSY = 0, ERR = 0, all CC_* outputs = 0, state IDLE, count = 0, `last` = 1.
- Input path is registered: CC_IN_* in cycle t+1 equals IN_*n in cycle t; this gives 1-cycle latency and keeps the forwarded burst contiguous.
- Output path is registered: OUT_VALIDn/OUTn in cycle t+1 equals CC_OUT_VALID/CC_OUT in cycle t.
- Request to grant: REQ high in cycle t (state IDLE) gives GNT high in cycle t+1.
- Back-to-back jobs: the next GNT rises no earlier than 2 cycles after the last OUT_VALIDn (one GAP cycle plus one IDLE cycle).
- A REQ raised by the other port during a job is held pending and served after GAP.
- RESET mid-job: all outputs return to reset values next cycle and the job is lost. The core shares RESET.

## Configuration
- CCARB_TIMEOUT_EN defined: a counter runs in GRANT. If TIMEOUT cycles elapse with no IN_VALIDn, ERR pulses, the grant is revoked and the state goes to GAP.
- Not defined: GRANT waits indefinitely, exiting only on IN_VALIDn or REQn low. ERR is raised only for overlength.

## Test plan
- Single job: REQ0; 3 samples A = {1,2,3}, B = {1,1,1}, MODE = 0 -> core sees the same burst 1 cycle later; OUT_VALID0 high 5 cycles, OUT0 = {1,3,6,5,3}; OUT_VALID1 stays 0.
- Contention: REQ0 and REQ1 high in the same cycle after reset -> GNT0 first. After GAP, GNT1, with its circular result {6,6,6} for A = {1,2,3}, B = {1,1,1}, MODE = 1.
- Round-robin: REQ0 is re-raised during requester 1's job and again later -> grants alternate 0,1,0. Requester 0 is never granted twice while REQ1 is pending.
- Overlength: 11-sample burst -> exactly 9 forwarded, ERR pulses on the 10th, and result routes to the owner.
- Timeout (macro on): GNT1 with no IN_VALID1 for 16 cycles -> ERR pulse, GNT1 falls, pending REQ0 granted.
- Reset mid-STREAM -> all outputs 0 next cycle, then a fresh single job completes correctly.

Source files
------------

// File: rtl/cc_arbiter.sv
// cc_arbiter: round-robin two-port arbiter and sequencer in front of the serial convolution core.
// Define CCARB_TIMEOUT_EN to revoke a grant that sees no input burst within TIMEOUT cycles.
module cc_arbiter #(
  parameter int MAX_LEN = 9,
  parameter int TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               REQ0,
  input  logic               REQ1,
  output logic               GNT0,
  output logic               GNT1,
  input  logic               IN_VALID0,
  input  logic               IN_VALID1,
  input  logic               MODE0,
  input  logic               MODE1,
  input  logic signed [7:0]  IN_A0,
  input  logic signed [7:0]  IN_A1,
  input  logic signed [7:0]  IN_B0,
  input  logic signed [7:0]  IN_B1,
  output logic               OUT_VALID0,
  output logic               OUT_VALID1,
  output logic signed [18:0] OUT0,
  output logic signed [18:0] OUT1,
  output logic               BUSY,
  output logic               ERR,
  output logic               CC_IN_VALID,
  output logic               CC_MODE,
  output logic signed [7:0]  CC_IN_A,
  output logic signed [7:0]  CC_IN_B,
  input  logic               CC_OUT_VALID,
  input  logic signed [18:0] CC_OUT
);
  localparam int CW = $clog2(MAX_LEN + 1);
  typedef enum logic [2:0] {IDLE, GRANT, STREAM, WAIT_OUT, GAP} state_t;
  state_t state, state_nxt;
  logic owner, owner_nxt, last, seen, seen_nxt;
  logic fwd, first, err_nxt, tmo_hit, pick, rte, granted_nxt;
  logic req_o, in_v_o, mode_o;
  logic signed [7:0] a_o, b_o;
  logic [CW-1:0] count, count_nxt;
  assign req_o = owner ? REQ1 : REQ0;
  assign in_v_o = owner ? IN_VALID1 : IN_VALID0;
  assign mode_o = owner ? MODE1 : MODE0;
  assign a_o = owner ? IN_A1 : IN_A0;
  assign b_o = owner ? IN_B1 : IN_B0;
  // Prefer the requester that did not own the previous job.
  assign pick = (last ? REQ0 : REQ1) ? ~last : last;
  assign rte = state inside {GRANT, STREAM, WAIT_OUT};
  assign granted_nxt = state_nxt inside {GRANT, STREAM, WAIT_OUT};
  assign BUSY = state != IDLE;
`ifdef CCARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmo;
  assign tmo_hit = tmo == TW'(TIMEOUT - 1);
  always_ff @(posedge CLK) tmo <= (RESET || state != GRANT) ? '0 : tmo + 1'b1;
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    count_nxt = count;
    fwd = 1'b0;
    first = 1'b0;
    err_nxt = 1'b0;
    case (state)
      IDLE: if (REQ0 || REQ1) begin
        state_nxt = GRANT;
        owner_nxt = pick;
      end
      GRANT: if (in_v_o) begin
        fwd = 1'b1;
        first = 1'b1;
        count_nxt = CW'(1);
        state_nxt = STREAM;
      end else if (!req_o) state_nxt = GAP;
      else if (tmo_hit) begin
        err_nxt = 1'b1;
        state_nxt = GAP;
      end
      STREAM: if (!in_v_o) state_nxt = WAIT_OUT;
      else if (count == CW'(MAX_LEN)) begin
        err_nxt = 1'b1;
        state_nxt = WAIT_OUT;
      end else begin
        fwd = 1'b1;
        count_nxt = count + 1'b1;
      end
      WAIT_OUT: if (seen && !CC_OUT_VALID) state_nxt = GAP;
      GAP: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
    seen_nxt = (state == STREAM || state == WAIT_OUT) && (seen || CC_OUT_VALID);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      count <= '0;
      seen <= 1'b0;
      GNT0 <= 1'b0;
      GNT1 <= 1'b0;
      ERR <= 1'b0;
      CC_IN_VALID <= 1'b0;
      CC_MODE <= 1'b0;
      CC_IN_A <= '0;
      CC_IN_B <= '0;
      OUT_VALID0 <= 1'b0;
      OUT_VALID1 <= 1'b0;
      OUT0 <= '0;
      OUT1 <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      count <= count_nxt;
      seen <= seen_nxt;
      if (state == GAP) last <= owner;
      GNT0 <= granted_nxt && !owner_nxt;
      GNT1 <= granted_nxt && owner_nxt;
      ERR <= err_nxt;
      CC_IN_VALID <= fwd;
      CC_MODE <= first && mode_o;
      CC_IN_A <= fwd ? a_o : '0;
      CC_IN_B <= fwd ? b_o : '0;
      OUT_VALID0 <= rte && !owner && CC_OUT_VALID;
      OUT_VALID1 <= rte && owner && CC_OUT_VALID;
      OUT0 <= (rte && !owner) ? CC_OUT : '0;
      OUT1 <= (rte && owner) ? CC_OUT : '0;
    end
  end
endmodule

// File: tb/tb_cc_arbiter.sv
// tb_cc_arbiter: directed scoreboard bench for cc_arbiter; the bench plays the convolution core.
module tb_cc_arbiter;
  localparam int MAX_LEN = 9;
  logic CLK, RESET, REQ0, REQ1, GNT0, GNT1, IN_VALID0, IN_VALID1, MODE0, MODE1;
  logic signed [7:0] IN_A0, IN_A1, IN_B0, IN_B1, CC_IN_A, CC_IN_B;
  logic OUT_VALID0, OUT_VALID1, BUSY, ERR, CC_IN_VALID, CC_MODE, CC_OUT_VALID;
  logic signed [18:0] OUT0, OUT1, CC_OUT;
  logic [16:0] qin[$];
  logic signed [18:0] q0[$], q1[$], res_q[$];
  int checks = 0;
  int errors = 0;
  cc_arbiter dut (
    .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1), .GNT0(GNT0), .GNT1(GNT1),
    .IN_VALID0(IN_VALID0), .IN_VALID1(IN_VALID1), .MODE0(MODE0), .MODE1(MODE1),
    .IN_A0(IN_A0), .IN_A1(IN_A1), .IN_B0(IN_B0), .IN_B1(IN_B1),
    .OUT_VALID0(OUT_VALID0), .OUT_VALID1(OUT_VALID1), .OUT0(OUT0), .OUT1(OUT1),
    .BUSY(BUSY), .ERR(ERR), .CC_IN_VALID(CC_IN_VALID), .CC_MODE(CC_MODE),
    .CC_IN_A(CC_IN_A), .CC_IN_B(CC_IN_B), .CC_OUT_VALID(CC_OUT_VALID), .CC_OUT(CC_OUT)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_in(input bit p, input logic v, input logic m, input logic signed [7:0] a, input logic signed [7:0] b);
    if (p) begin
      IN_VALID1 = v; MODE1 = m; IN_A1 = a; IN_B1 = b;
    end else begin
      IN_VALID0 = v; MODE0 = m; IN_A0 = a; IN_B0 = b;
    end
  endtask
  // Owner streams n samples while the other port drives junk that must be ignored.
  task automatic burst(input bit p, input bit m, input int n);
    logic signed [7:0] a, b;
    for (int k = 0; k < n; k++) begin
      a = 8'(k + 1);
      b = (n > MAX_LEN) ? 8'(-(k + 1)) : 8'sd1;
      set_in(p, 1'b1, m, a, b);
      set_in(!p, 1'b1, 1'b1, -8'sd128, 8'sd127);
      if (k == 0) begin
        if (p) REQ1 = 1'b0;
        else REQ0 = 1'b0;
      end
      if (k < MAX_LEN) qin.push_back({((k == 0) ? m : 1'b0), a, b});
      tick();
      chk("err_pulse", ERR, k == MAX_LEN);
    end
    set_in(p, 1'b0, 1'b0, 8'sd0, 8'sd0);
    set_in(!p, 1'b0, 1'b0, 8'sd0, 8'sd0);
    tick();
    chk("err_after_burst", ERR, 0);
  endtask
  task automatic results(input bit p);
    foreach (res_q[i]) begin
      CC_OUT_VALID = 1'b1;
      CC_OUT = res_q[i];
      if (p) q1.push_back(res_q[i]);
      else q0.push_back(res_q[i]);
      tick();
    end
    CC_OUT_VALID = 1'b0;
    CC_OUT = 19'sh12345;
    tick();
    chk("gnt_low_in_gap", p ? GNT1 : GNT0, 0);
    chk("busy_in_gap", BUSY, 1);
    chk("out_drained", p ? q1.size() : q0.size(), 0);
  endtask
  task automatic mon();
    logic [16:0] ei;
    logic signed [18:0] e;
    if (CC_IN_VALID) begin
      ei = (qin.size() != 0) ? qin.pop_front() : 17'bx;
      chk("cc_in", {CC_MODE, CC_IN_A, CC_IN_B}, ei);
    end else chk("cc_mode_idle", CC_MODE, 0);
    if (OUT_VALID0) begin
      e = (q0.size() != 0) ? q0.pop_front() : 19'bx;
      chk("out0", OUT0, e);
    end
    if (OUT_VALID1) begin
      e = (q1.size() != 0) ? q1.pop_front() : 19'bx;
      chk("out1", OUT1, e);
    end
    if (GNT1) chk("out0_masked", {OUT_VALID0, OUT0}, 0);
    if (GNT0) chk("out1_masked", {OUT_VALID1, OUT1}, 0);
  endtask
  initial begin
    {REQ0, REQ1, IN_VALID0, IN_VALID1, MODE0, MODE1, CC_OUT_VALID} = '0;
    {IN_A0, IN_A1, IN_B0, IN_B1} = '0;
    CC_OUT = 19'sh12345;
    RESET = 1'b1;
    fork
      forever begin
        @(negedge CLK);
        mon();
      end
    join_none
    tick();
    tick();
    chk("rst_gnt0", GNT0, 0);
    chk("rst_gnt1", GNT1, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);
    chk("rst_cc_in", {CC_IN_VALID, CC_MODE, CC_IN_A, CC_IN_B}, 0);
    chk("rst_out", {OUT_VALID0, OUT_VALID1, OUT0, OUT1}, 0);
    RESET = 1'b0;
    REQ0 = 1'b1;
    tick();
    chk("single_gnt0", GNT0, 1);
    chk("single_gnt1", GNT1, 0);
    chk("single_busy", BUSY, 1);
    burst(0, 1'b0, 3);
    res_q = '{19'sd1, 19'sd3, 19'sd6, 19'sd5, 19'sd3};
    results(0);
    tick();
    chk("single_idle", BUSY, 0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    tick();
    chk("cont_gnt0", GNT0, 1);
    chk("cont_gnt1", GNT1, 0);
    burst(0, 1'b0, 3);
    res_q = '{19'sd1, 19'sd3, 19'sd6, 19'sd5, 19'sd3};
    results(0);
    tick();
    chk("cont_idle_gnt1", GNT1, 0);
    tick();
    chk("cont_gnt1_after", GNT1, 1);
    chk("cont_gnt0_after", GNT0, 0);
    REQ0 = 1'b1;
    burst(1, 1'b1, 3);
    res_q = '{19'sd6, 19'sd6, 19'sd6};
    results(1);
    tick();
    tick();
    chk("rr_gnt0", GNT0, 1);
    chk("rr_gnt1", GNT1, 0);
    REQ1 = 1'b1;
    burst(0, 1'b0, 11);
    res_q = '{19'sh40000, 19'sh3FFFF, -19'sd1, 19'sd0, 19'sd77};
    results(0);
    REQ0 = 1'b1;
    tick();
    tick();
    chk("rr_gnt1_pending", GNT1, 1);
    chk("rr_gnt0_held", GNT0, 0);
`ifdef CCARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("tmo_err", ERR, k == 16);
      chk("tmo_gnt1", GNT1, k < 16);
    end
    REQ1 = 1'b0;
    tick();
    chk("tmo_err_end", ERR, 0);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("wait_err", ERR, 0);
      chk("wait_gnt1", GNT1, 1);
    end
    REQ1 = 1'b0;
    tick();
    chk("cancel_gnt1", GNT1, 0);
    tick();
`endif
    tick();
    chk("pend_gnt0", GNT0, 1);
    burst(0, 1'b0, 3);
    res_q = '{19'sd1, 19'sd3, 19'sd6, 19'sd5, 19'sd3};
    results(0);
    tick();
    REQ1 = 1'b1;
    tick();
    chk("pre_rst_gnt1", GNT1, 1);
    for (int k = 0; k < 2; k++) begin
      set_in(1, 1'b1, 1'b1, 8'(k + 10), -8'sd3);
      if (k == 0) REQ1 = 1'b0;
      qin.push_back({(k == 0), 8'(k + 10), -8'sd3});
      tick();
    end
    set_in(1, 1'b1, 1'b0, 8'sd99, 8'sd99);
    RESET = 1'b1;
    tick();
    chk("mid_rst_gnt", {GNT0, GNT1}, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_err", ERR, 0);
    chk("mid_rst_cc_in", {CC_IN_VALID, CC_MODE, CC_IN_A, CC_IN_B}, 0);
    chk("mid_rst_out", {OUT_VALID0, OUT_VALID1, OUT0, OUT1}, 0);
    chk("mid_rst_qin", qin.size(), 0);
    RESET = 1'b0;
    set_in(1, 1'b0, 1'b0, 8'sd0, 8'sd0);
    REQ1 = 1'b1;
    tick();
    chk("post_rst_gnt1", GNT1, 1);
    burst(1, 1'b0, 3);
    res_q = '{19'sd1, 19'sd3, 19'sd6, 19'sd5, 19'sd3};
    results(1);
    tick();
    tick();
    chk("final_busy", BUSY, 0);
    chk("final_qin", qin.size(), 0);
    chk("final_q0", q0.size(), 0);
    chk("final_q1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
